// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the binary-to-BCD conversion controller and
// its sequential divide-by-10 unit.
//   state_t       : controller FSM states
//   MAX_VAL       : largest value representable in four BCD digits
//   DIV_STEPS     : restoring-divider iterations (one quotient bit each)
//   DIVISOR_INIT  : 10 aligned to the top quotient bit (10 << 10)
//   SAT_DIGITS    : digits shown when the input is out of range
//   NUM_DIGITS    : number of BCD digits produced
//   calc_blank()  : leading-zero blanking mask for a 4-digit BCD word
// ----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        STORE,
        DONE
    } state_t;

    localparam logic [13:0] MAX_VAL      = 14'd9999;
    localparam int          DIV_STEPS    = 11;
    localparam logic [13:0] DIVISOR_INIT = 14'h2800;
    localparam logic [15:0] SAT_DIGITS   = 16'h9999;
    localparam int          NUM_DIGITS   = 4;

    // A digit is blanked only when it and every more-significant digit are
    // zero; the units digit is always shown so that zero reads as "0".
    function automatic logic [3:0] calc_blank(input logic [15:0] bcd);
        logic [3:0] b;
        b    = '0;
        b[3] = (bcd[15:12] == 4'd0);
        b[2] = b[3] && (bcd[11:8] == 4'd0);
        b[1] = b[2] && (bcd[7:4] == 4'd0);
        b[0] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/div10_seq.sv
// ----------------------------------------------------------------------------
// div10_seq
// Iterative restoring divide-by-10. One quotient bit is resolved per clock,
// MSB first; the first bit is resolved on the div_start edge itself, so the
// results are final and div_done pulses exactly DIV_STEPS cycles after
// div_start.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, clears all divider state
//   div_start  : one-cycle start strobe, samples dividend
//   dividend   : 14-bit unsigned dividend
//   div_done   : one-cycle pulse, quotient/remainder valid from this cycle
//   quotient   : 11-bit quotient
//   remainder  : 4-bit remainder (0..9)
// ----------------------------------------------------------------------------
module div10_seq
    import bcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic [13:0] dividend,
    output logic        div_done,
    output logic [10:0] quotient,
    output logic [3:0]  remainder
);

    logic [13:0] r_rem;
    logic [13:0] r_div;
    logic [10:0] r_quo;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;

    logic [13:0] w_rem_src;
    logic [13:0] w_div_src;
    logic        w_bit;
    logic [13:0] w_rem_nxt;

    // The start cycle feeds the step from the inputs so no cycle is spent
    // just loading; afterwards the step runs on the held partial remainder.
    assign w_rem_src = div_start ? dividend : r_rem;
    assign w_div_src = div_start ? DIVISOR_INIT : r_div;
    assign w_bit     = (w_rem_src >= w_div_src);
    assign w_rem_nxt = w_bit ? (w_rem_src - w_div_src) : w_rem_src;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (div_start) begin
                r_rem  <= w_rem_nxt;
                r_div  <= DIVISOR_INIT >> 1;
                r_quo  <= {10'd0, w_bit};
                r_cnt  <= 4'd1;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nxt;
                r_div <= r_div >> 1;
                r_quo <= {r_quo[9:0], w_bit};
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'(DIV_STEPS - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign div_done  = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem[3:0];

endmodule

// File: rtl/bcd_convert_ctrl.sv
// ----------------------------------------------------------------------------
// bcd_convert_ctrl
// Converts a 14-bit binary value to four BCD digits by repeated division by
// 10, building the result in a shadow register and publishing it, together
// with a leading-zero blanking mask, in a single DONE cycle so a display
// never sees a partial update. Values above 9999 saturate to 9999 with ovf.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (aborts any conversion)
//   req    : conversion request, honoured only when idle
//   value  : binary input, sampled on the accepting edge
//   busy   : high while the FSM is not IDLE
//   done   : one-cycle pulse in the DONE state
//   digits : published BCD result {d3,d2,d1,d0}
//   blank  : leading-zero blanking mask, bit i blanks digit i
//   ovf    : last accepted value exceeded 9999
// ----------------------------------------------------------------------------
module bcd_convert_ctrl
    import bcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [13:0] value,
    output logic        busy,
    output logic        done,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        ovf
);

    // Index of the last STORE; the remaining top digit is the final quotient.
    localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 2);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [13:0] r_work;
    logic [1:0]  r_idx;
    logic [15:0] r_shadow;
    logic        r_ovf_shadow;
    logic [15:0] r_digits;
    logic [3:0]  r_blank;
    logic        r_ovf;

    logic        w_div_start;
    logic        w_div_done;
    logic [10:0] w_quotient;
    logic [3:0]  w_remainder;
    logic        w_busy;
    logic        w_done;

    div10_seq u_div (
        .clk       (clk),
        .rst       (rst),
        .div_start (w_div_start),
        .dividend  (r_work),
        .div_done  (w_div_done),
        .quotient  (w_quotient),
        .remainder (w_remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (req) w_state_nxt = (value > MAX_VAL) ? DONE : LOAD;
            end
            LOAD: begin
                w_div_start = 1'b1;
                w_state_nxt = DIV;
            end
            DIV: begin
                if (w_div_done) w_state_nxt = STORE;
            end
            STORE: begin
                w_state_nxt = (r_idx == LAST_IDX) ? DONE : LOAD;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work       <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_ovf_shadow <= 1'b0;
            r_digits     <= '0;
            r_blank      <= '0;
            r_ovf        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req) begin
                        r_work <= value;
                        r_idx  <= '0;
                        if (value > MAX_VAL) begin
                            r_shadow     <= SAT_DIGITS;
                            r_ovf_shadow <= 1'b1;
                        end else begin
                            r_ovf_shadow <= 1'b0;
                        end
                    end
                end
                STORE: begin
                    case (r_idx)
                        2'd0:    r_shadow[3:0]  <= w_remainder;
                        2'd1:    r_shadow[7:4]  <= w_remainder;
                        default: r_shadow[11:8] <= w_remainder;
                    endcase
                    // After the last division the quotient is below 10 and is
                    // itself the thousands digit.
                    if (r_idx == LAST_IDX) r_shadow[15:12] <= w_quotient[3:0];
                    r_work <= {3'b000, w_quotient};
                    r_idx  <= r_idx + 2'd1;
                end
                DONE: begin
                    r_digits <= r_shadow;
                    r_ovf    <= r_ovf_shadow;
                    r_blank  <= r_ovf_shadow ? 4'b0000 : calc_blank(r_shadow);
                end
                default: ;
            endcase
        end
    end

    assign busy   = w_busy;
    assign done   = w_done;
    assign digits = r_digits;
    assign blank  = r_blank;
    assign ovf    = r_ovf;

endmodule
